// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache/memory interface constants, line/beat types and the adaptor state encoding.
// Imported by cache_control, the cache datapath and cacheline_adaptor so widths agree everywhere.
package cacheline_adaptor_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int BURST_LEN   = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W       = $clog2(BURST_LEN);

    typedef logic [LINE_WIDTH-1:0]  cacheline_t;
    typedef logic [BURST_WIDTH-1:0] burst_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one cache-line read/write into a BURST_LEN-beat memory burst; latency 1 accept + beats + 1 done.
// Beats advance only on resp_i, so memory stalls simply hold the burst; resp_o is a one-cycle pulse.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);

    adaptor_state_e         state_q;
    adaptor_state_e         state_d;
    logic [CNT_W-1:0]       cnt_q;
    cacheline_t             buf_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  addr_aligned;
    logic                   last_beat;

    assign addr_aligned = {address_i[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign last_beat    = resp_i && (cnt_q == CNT_W'(BURST_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write has priority when the cache raises both requests together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (write_i) begin
                    state_d = ST_WRITE;
                end else if (read_i) begin
                    state_d = ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The counter wraps to zero after the last beat, so DONE always leaves it cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            buf_q  <= '0;
            addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (write_i) begin
                        buf_q  <= line_i;
                        addr_q <= addr_aligned;
                        cnt_q  <= '0;
                    end else if (read_i) begin
                        addr_q <= addr_aligned;
                        cnt_q  <= '0;
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        buf_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_o    = (state_q == ST_READ);
    assign write_o   = (state_q == ST_WRITE);
    assign resp_o    = (state_q == ST_DONE);
    assign address_o = addr_q;
    assign line_o    = buf_q;
    assign burst_o   = buf_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of cache_control and the cache datapath, between the cache's physical-memory port and the burst-oriented main memory.
- Converts one cache-line request into a fixed-length burst of narrower beats:
  - Reads: collects BURST_LEN beats into a full line.
  - Writes (dirty write-back): splits the captured line into BURST_LEN beats.
- Presents a single-cycle response pulse back to the cache.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory beat width in bits.
- ADDR_WIDTH, 32, byte address width.
- BURST_LEN is derived (LINE_WIDTH/BURST_WIDTH = 4); it is not overridable.
- OFFSET_BITS is derived (log2(LINE_WIDTH/8) = 5).

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- address_i  in  ADDR_WIDTH  line address from cache (pmem_address)
- read_i  in  1  line read request from cache_control (pmem_read), level, held until resp_o
- write_i  in  1  line write request from cache_control (pmem_write), level, held until resp_o
- line_i  in  LINE_WIDTH  line to write back
- line_o  out  LINE_WIDTH  assembled read line
- resp_o  out  1  one-cycle completion pulse (pmem_resp)
- address_o  out  ADDR_WIDTH  line-aligned burst address to memory
- read_o  out  1  burst read request to memory
- write_o  out  1  burst write request to memory
- burst_o  out  BURST_WIDTH  current write beat
- burst_i  in  BURST_WIDTH  read beat from memory, valid when resp_i=1
- resp_i  in  1  memory beat accept/valid strobe

Behaviour:
- Reset (rst_n=0, async, any state): state=IDLE, beat count=0, line buffer=0.
  - Outputs: resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0.
  - Reset mid-burst abandons the transfer with no resp_o.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1 -> WRITE. Capture line_i into the buffer and address_o={address_i[ADDR_WIDTH-1:OFFSET_BITS], 0}. count=0.
  - else read_i=1 -> READ. Capture the address the same way. count=0.
  - Both read_i and write_i high: write wins.
- READ:
  - read_o=1 for the whole state.
  - Each cycle with resp_i=1: buffer[count*BURST_WIDTH +: BURST_WIDTH] <= burst_i, count++.
  - Beat 0 is the lowest bits. Gaps in resp_i are allowed and simply stall the count.
  - resp_i with count==BURST_LEN-1 -> DONE.
- WRITE:
  - write_o=1. burst_o=buffer[count*BURST_WIDTH +: BURST_WIDTH], combinational from count.
  - Each resp_i=1 advances count.
  - resp_i on the last beat -> DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; -> IDLE unconditionally.
  - The request sampled in that IDLE cycle is treated as a new request.
- line_o is driven from the buffer. It is valid in the resp_o cycle and held until the next accepted request.
- Count width is log2(BURST_LEN). It wraps to 0 after the last beat; count is cleared on every entry from IDLE.
- resp_i while in IDLE or DONE is ignored.
- address_o is held stable from acceptance until DONE.
- Latency: read or write completes with resp_o one cycle after the last resp_i beat. Minimum is 1 (accept) + 4 (beats) + 1 (DONE) = 6 cycles from request to resp_o.
- Requests that drop before resp_o are not supported: the transfer completes anyway.

Decomposition:
- Shared package (rv32i_types or a sibling cache_types) holds:
  - LINE_WIDTH, BURST_WIDTH, BURST_LEN, OFFSET_BITS constants.
  - typedef cacheline_t (logic [255:0]).
  - typedef burst_t (logic [63:0]).
  - Adaptor state enum.
- cache_control and the cache datapath import the same constants.
- No sub-module required; the beat counter is inline. Optional shared helper: burst_counter (modulo-BURST_LEN counter with clear/enable).

Test Plan:
- Read, back-to-back beats: read_i=1, address_i=0x0000_1234. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles with resp_i=1.
  - Required: address_o=0x0000_1220.
  - Required: line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
  - Required: resp_o high exactly one cycle, one cycle after the 4th beat.
- Write with stalls: write_i=1, line_i={D3,D2,D1,D0}, resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o=D0,D1,D1,D1,D2,D3,D3 on those cycles.
  - Required: write_o high throughout, then resp_o pulse, then write_o=0.
- Simultaneous read_i=1 and write_i=1 in IDLE: required write_o=1, read_o=0, burst_o=line_i[63:0].
- Reset after 2 read beats (rst_n=0 asynchronously): required read_o, resp_o and line_o all 0 immediately. After release, a new read of 0x80 completes normally with fresh data.
- Back-to-back: read completes, cache asserts write_i in the cycle after resp_o. Required: write accepted in that IDLE cycle, write_o=1 next cycle.
- Spurious resp_i=1 while IDLE: required no state change and no resp_o.
